// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream program loader; writes a length-prefixed image into
//            instruction memory and holds the core in reset until it is done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_rst
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  // Capacity is one bit wider than the header so the compare never truncates.
  localparam logic [32:0]         C_CAP = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           asm_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic                  rx_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [31:0]           mem_wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  cpu_rst_q;

  logic        w_accept;
  logic        w_last_byte;
  logic [31:0] w_asm;

  assign w_accept    = rx_valid & rx_ready_q;
  assign w_last_byte = (byte_cnt_q == 2'd3);
  // Little-endian: each new byte enters at the top, so byte 0 ends at [7:0].
  assign w_asm       = {rx_data, asm_q[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'd0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      rx_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_q   <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (w_accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= w_asm;
            busy_q     <= 1'b1;
            if (w_last_byte) begin
              if (w_asm == 32'd0) begin
                state_q    <= S_DONE;
                rx_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                cpu_rst_q  <= 1'b0;
              end else if ({1'b0, w_asm} > C_CAP) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_DATA;
                len_q   <= w_asm[ADDR_WIDTH:0];
              end
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= w_asm;
            if (w_last_byte) begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= word_cnt_q[ADDR_WIDTH-1:0];
              mem_wdata_q <= w_asm;
              word_cnt_q  <= word_cnt_q + C_ONE;
              if (word_cnt_q == len_q - C_ONE) begin
                state_q    <= S_DONE;
                rx_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                cpu_rst_q  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          rx_ready_q <= 1'b0;
        end
        default: begin
          // Error sink: keep draining the link so the sender never stalls.
          rx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst   = cpu_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench; two loader instances (12-bit and 4-bit
//            address) see the same byte stream and track a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        a_rx_ready, a_mem_we, a_busy, a_done, a_err, a_cpu_rst;
  logic [11:0] a_mem_waddr;
  logic [31:0] a_mem_wdata;
  logic        b_rx_ready, b_mem_we, b_busy, b_done, b_err, b_cpu_rst;
  logic [3:0]  b_mem_waddr;
  logic [31:0] b_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  imem_loader #(.ADDR_WIDTH(12)) u_dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(a_rx_ready), .mem_we(a_mem_we), .mem_waddr(a_mem_waddr),
    .mem_wdata(a_mem_wdata), .busy(a_busy), .done(a_done), .err(a_err),
    .cpu_rst(a_cpu_rst)
  );

  imem_loader #(.ADDR_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(b_rx_ready), .mem_we(b_mem_we), .mem_waddr(b_mem_waddr),
    .mem_wdata(b_mem_wdata), .busy(b_busy), .done(b_done), .err(b_err),
    .cpu_rst(b_cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream-level model: counts accepted bytes since reset and derives status.
  longint      m_cap   [2] = '{64'd4096, 64'd16};
  int          m_nb    [2];
  longint      m_len   [2];
  longint      m_words [2];
  logic [31:0] m_cur   [2];
  bit          m_we    [2];
  longint      m_waddr [2];
  logic [31:0] m_wdata [2];

  function automatic bit m_done(input int k);
    return (m_nb[k] >= 4) && (m_len[k] <= m_cap[k]) && (m_words[k] == m_len[k]);
  endfunction

  function automatic bit m_err(input int k);
    return (m_nb[k] >= 4) && (m_len[k] > m_cap[k]);
  endfunction

  task automatic m_update(input int k, input bit r, input bit v, input logic [7:0] d);
    m_we[k] = 1'b0;
    if (r) begin
      m_nb[k] = 0; m_len[k] = 0; m_words[k] = 0; m_cur[k] = 32'd0;
      m_waddr[k] = 0; m_wdata[k] = 32'd0;
    end else if (v && !m_done(k) && !m_err(k)) begin
      if ((m_nb[k] % 4) == 0) m_cur[k] = 32'd0;
      m_cur[k] = m_cur[k] | (32'(d) << (8 * (m_nb[k] % 4)));
      m_nb[k]++;
      if (m_nb[k] == 4) begin
        m_len[k] = longint'(m_cur[k]);
      end else if ((m_nb[k] % 4) == 0) begin
        m_we[k]    = 1'b1;
        m_waddr[k] = m_words[k];
        m_wdata[k] = m_cur[k];
        m_words[k]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic chk_dut(input int k, input logic rdy, input logic we,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic bsy, input logic dn, input logic er,
                         input logic crst);
    string p;
    p = (k == 0) ? "a." : "b.";
    chk({p, "rx_ready"}, 64'(rdy), 64'(!m_done(k)));
    chk({p, "mem_we"},   64'(we),  64'(m_we[k]));
    chk({p, "mem_waddr"}, 64'(wa), 64'(m_waddr[k]));
    chk({p, "mem_wdata"}, 64'(wd), 64'(m_wdata[k]));
    chk({p, "busy"},     64'(bsy), 64'(m_nb[k] > 0 && !m_done(k) && !m_err(k)));
    chk({p, "done"},     64'(dn),  64'(m_done(k)));
    chk({p, "err"},      64'(er),  64'(m_err(k)));
    chk({p, "cpu_rst"},  64'(crst), 64'(!m_done(k)));
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    rst = r; rx_valid = v; rx_data = d;
    @(posedge clk);
    m_update(0, r, v, d);
    m_update(1, r, v, d);
    @(negedge clk);
    chk_dut(0, a_rx_ready, a_mem_we, 32'(a_mem_waddr), a_mem_wdata,
            a_busy, a_done, a_err, a_cpu_rst);
    chk_dut(1, b_rx_ready, b_mem_we, 32'(b_mem_waddr), b_mem_wdata,
            b_busy, b_done, b_err, b_cpu_rst);
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    repeat (gap) step(1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, d);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send(w[7:0], gap); send(w[15:8], gap); send(w[23:16], gap); send(w[31:24], gap);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] len;
    int          nbytes;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    do_reset();

    // Normal load, back-to-back
    send_word(32'd2, 0); send_word(32'h00000013, 0); send_word(32'h00100093, 0);
    chk("t1.addr", 64'(a_mem_waddr), 64'd1);
    chk("t1.data", 64'(a_mem_wdata), 64'h00100093);
    chk("t1.done", 64'(a_done), 64'd1);
    repeat (3) step(1'b0, 1'b1, 8'hAA);
    chk("t1.rx_ready", 64'(a_rx_ready), 64'd0);

    // Gapped stream
    do_reset();
    send_word(32'd2, 3); send_word(32'h00000013, 3); send_word(32'h00100093, 3);

    // Zero length
    do_reset();
    send_word(32'd0, 0);
    chk("t3.done", 64'(a_done), 64'd1);

    // Over-capacity for both instances
    do_reset();
    send_word(32'd4097, 0);
    repeat (8) send(8'($urandom), 0);
    chk("t4.err", 64'(a_err), 64'd1);
    chk("t4.rx_ready", 64'(a_rx_ready), 64'd1);

    // Reset mid-load
    do_reset();
    send_word(32'd2, 0);
    repeat (6) send(8'($urandom), 0);
    step(1'b1, 1'b0, 8'h00);
    send_word(32'd1, 0); send_word(32'hDEADBEEF, 0);
    chk("t5.data", 64'(a_mem_wdata), 64'hDEADBEEF);
    chk("t5.done", 64'(a_done), 64'd1);

    // Exact capacity of the small instance, then of the large one
    do_reset();
    send_word(32'd16, 0);
    repeat (64) send(8'($urandom), 0);
    chk("t6.b_done", 64'(b_done), 64'd1);
    chk("t6.b_addr", 64'(b_mem_waddr), 64'd15);
    repeat (4) step(1'b0, 1'b1, 8'h55);
    do_reset();
    send_word(32'd4096, 0);
    repeat (4 * 4096) send(8'($urandom), 0);
    chk("t6.a_done", 64'(a_done), 64'd1);
    chk("t6.a_addr", 64'(a_mem_waddr), 64'd4095);

    // Randomized images with gaps and occasional mid-stream reset
    for (int it = 0; it < 40; it++) begin
      do_reset();
      case ($urandom_range(0, 5))
        0:       len = 32'($urandom_range(0, 4));
        1:       len = 32'($urandom_range(15, 17));
        2:       len = $urandom;
        default: len = 32'($urandom_range(1, 6));
      endcase
      send_word(len, int'($urandom_range(0, 2)));
      nbytes = 4 * ((len > 32'd6) ? 6 : int'(len)) + int'($urandom_range(0, 5));
      for (int i = 0; i < nbytes; i++) begin
        if ($urandom_range(0, 39) == 0) step(1'b1, 1'b0, 8'h00);
        send(8'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
